rca_sum_accumulator: RTL and testbench

Downstream consumer of the 4-bit ripple carry adder. Each accepted sample is the adder result {cout, sum}, taken as an unsigned DATA_W+1-bit value. The block sums FRAME_LEN samples into an ACC_W-bit accumulator, then presents the frame total on a valid/ready output. It gives a registered, flow-controlled reduction stage after the combinational adder, with sticky overflow detection.

---
 rtl/rca_sum_accumulator.sv | 98 +++++++++
 tb/tb_rca_sum_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_sum_accumulator.sv
// Frame accumulator behind the ripple carry adder: sums FRAME_LEN
// {cout,sum} samples and hands the total off on a valid/ready port.
module rca_sum_accumulator #(
   parameter int DATA_W    = 4,
   parameter int ACC_W     = 8,
   parameter int FRAME_LEN = 4,
   localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sum,
   input  logic              cout,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clr,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  sample_cnt
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             last;
   logic             release_f;
   logic [ACC_W:0]   sum_wide;

   assign accept    = in_valid && (state_q == ACCUM);
   assign last      = (cnt_q == CNT_W'(FRAME_LEN - 1));
   assign release_f = out_ready && (state_q == DONE);

   // Extra top bit of the wide add is the carry out of ACC_W bits.
   assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'({cout, sum});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ACCUM;
      end else if (clr) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM: begin
            if (accept && last) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ACCUM: in_ready  = 1'b1;
         DONE:  out_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (clr || release_f) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (accept) begin
         acc_q <= sum_wide[ACC_W-1:0];
         ovf_q <= ovf_q | sum_wide[ACC_W];
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign acc_out    = acc_q;
   assign ovf        = ovf_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Directed bench for rca_sum_accumulator: default instance plus a
// narrow ACC_W=6, FRAME_LEN=3 instance for overflow.
module tb_rca_sum_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sum;
   logic       cout;
   logic       in_valid, clr, out_ready;
   logic       in_valid2, clr2, out_ready2;

   logic       in_ready, ovf, out_valid;
   logic [7:0] acc_out;
   logic [2:0] sample_cnt;

   logic       in_ready2, ovf2, out_valid2;
   logic [5:0] acc_out2;
   logic [1:0] sample_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rca_sum_accumulator u_dut (
      .clk(clk), .rst_n(rst_n), .sum(sum), .cout(cout),
      .in_valid(in_valid), .in_ready(in_ready), .clr(clr),
      .acc_out(acc_out), .ovf(ovf), .out_valid(out_valid),
      .out_ready(out_ready), .sample_cnt(sample_cnt)
   );

   rca_sum_accumulator #(.DATA_W(4), .ACC_W(6), .FRAME_LEN(3)) u_ovf (
      .clk(clk), .rst_n(rst_n), .sum(sum), .cout(cout),
      .in_valid(in_valid2), .in_ready(in_ready2), .clr(clr2),
      .acc_out(acc_out2), .ovf(ovf2), .out_valid(out_valid2),
      .out_ready(out_ready2), .sample_cnt(sample_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for one cycle on the selected instance.
   task automatic put(input logic [4:0] s, input bit narrow);
      {cout, sum} = s;
      in_valid  = !narrow;
      in_valid2 = narrow;
      tick();
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
   endtask

   task automatic frame60();
      put(5'd3, 0);
      put(5'd11, 0);
      put(5'd30, 0);
      put(5'd16, 0);
   endtask

   task automatic release1();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_acc"}, 32'(acc_out), 0);
      check({tag, "_cnt"}, 32'(sample_cnt), 0);
      check({tag, "_ovf"}, 32'(ovf), 0);
      check({tag, "_ov"}, 32'(out_valid), 0);
      check({tag, "_ir"}, 32'(in_ready), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      {cout, sum} = 5'd0;
      in_valid = 0; clr = 0; out_ready = 0;
      in_valid2 = 0; clr2 = 0; out_ready2 = 0;
      tick();
      tick();
      chk_idle("reset");
      rst_n = 1'b1;

      // Back-to-back frame: 3 + 11 + 30 + 16 = 60
      {cout, sum} = 5'd3;  in_valid = 1; tick();
      check("b2b_cnt1", 32'(sample_cnt), 1);
      {cout, sum} = 5'd11; tick();
      {cout, sum} = 5'd30; tick();
      check("b2b_ov_early", 32'(out_valid), 0);
      {cout, sum} = 5'd16; tick();
      check("b2b_ov", 32'(out_valid), 1);
      check("b2b_acc", 32'(acc_out), 60);
      check("b2b_ovf", 32'(ovf), 0);
      check("b2b_cnt", 32'(sample_cnt), 4);
      check("b2b_ir", 32'(in_ready), 0);

      // Backpressure while junk is offered
      {cout, sum} = 5'h1F;
      for (int i = 0; i < 5; i++) tick();
      check("bp_acc", 32'(acc_out), 60);
      check("bp_cnt", 32'(sample_cnt), 4);
      check("bp_ov", 32'(out_valid), 1);
      in_valid = 0;
      release1();
      chk_idle("bp_rel");

      // Gapped input with garbage on the bus in the gaps
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: put(5'd3, 0);
            1: put(5'd11, 0);
            2: put(5'd30, 0);
            default: put(5'd16, 0);
         endcase
         if (i < 3) begin
            {cout, sum} = 5'h1F;
            tick();
            {cout, sum} = 5'bx;
            tick();
         end
      end
      check("gap_acc", 32'(acc_out), 60);
      check("gap_ov", 32'(out_valid), 1);
      release1();

      // Overflow on narrow instance: 30*3 = 90 mod 64 = 26
      put(5'd30, 1);
      put(5'd30, 1);
      check("ovf_acc2", 32'(acc_out2), 60);
      check("ovf_pre", 32'(ovf2), 0);
      put(5'd30, 1);
      check("ovf_acc", 32'(acc_out2), 26);
      check("ovf_set", 32'(ovf2), 1);
      check("ovf_ov", 32'(out_valid2), 1);
      check("ovf_cnt", 32'(sample_cnt2), 3);
      tick();
      check("ovf_hold", 32'(ovf2), 1);
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      check("ovf_rel", 32'(ovf2), 0);
      check("ovf_rel_acc", 32'(acc_out2), 0);
      check("ovf_rel_ov", 32'(out_valid2), 0);

      // clr mid-frame
      check("main_idle_acc", 32'(acc_out), 0);
      put(5'd3, 0);
      put(5'd11, 0);
      check("clr_pre", 32'(acc_out), 14);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_idle("clr");
      frame60();
      check("clr_next", 32'(acc_out), 60);
      check("clr_next_ov", 32'(out_valid), 1);
      release1();

      // Reset mid-frame
      put(5'd3, 0);
      rst_n = 1'b0;
      tick();
      tick();
      chk_idle("rst_mid");
      rst_n = 1'b1;
      put(5'd3, 0);
      check("rst_resume_acc", 32'(acc_out), 3);
      check("rst_resume_cnt", 32'(sample_cnt), 1);
      put(5'd11, 0);
      put(5'd30, 0);
      put(5'd16, 0);
      check("rst_full", 32'(acc_out), 60);
      check("rst_full_ov", 32'(out_valid), 1);

      // Reset while holding a result in DONE
      rst_n = 1'b0;
      tick();
      tick();
      chk_idle("rst_done");
      rst_n = 1'b1;
      put(5'd30, 0);
      check("rst_done_resume", 32'(acc_out), 30);
      check("rst_done_cnt", 32'(sample_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
